vending_controller: RTL

//   Parametrised vending controller: N products, per-product price and stock tables,

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_change_calc.sv | 35 +++
 rtl/vending_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
//   state_t        : top-level FSM states
//   COIN_*         : value in cents of each accepted coin
//   CHANGE_*       : denominations used for greedy change payout, largest first
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int COIN_NICKEL  = 5;
  localparam int COIN_DIME    = 10;
  localparam int COIN_QUARTER = 25;
  localparam int COIN_DOLLAR  = 100;

  localparam int CHANGE_QUARTER = 25;
  localparam int CHANGE_DIME    = 10;
  localparam int CHANGE_NICKEL  = 5;

endpackage

// File: rtl/vend_change_calc.sv
// Greedy change breakdown: splits a remaining credit into quarters, dimes
// and nickels. Any residue below a nickel is dropped.
// Ports:
//   rem    in   CREDIT_W   amount to pay out, cents
//   quart  out  CREDIT_W   number of quarters
//   dim    out  CREDIT_W   number of dimes
//   nick   out  CREDIT_W   number of nickels
module vend_change_calc
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 9
) (
  input  logic [CREDIT_W-1:0] rem,
  output logic [CREDIT_W-1:0] quart,
  output logic [CREDIT_W-1:0] dim,
  output logic [CREDIT_W-1:0] nick
);

  localparam logic [CREDIT_W-1:0] Q_VAL = CREDIT_W'(CHANGE_QUARTER);
  localparam logic [CREDIT_W-1:0] D_VAL = CREDIT_W'(CHANGE_DIME);
  localparam logic [CREDIT_W-1:0] N_VAL = CREDIT_W'(CHANGE_NICKEL);

  logic [CREDIT_W-1:0] after_quart;
  logic [CREDIT_W-1:0] after_dime;

  // Largest coin first; each stage works on what the previous one left over.
  always_comb begin
    quart       = rem / Q_VAL;
    after_quart = rem % Q_VAL;
    dim         = after_quart / D_VAL;
    after_dime  = after_quart % D_VAL;
    nick        = after_dime / N_VAL;
  end

endmodule

// File: rtl/vending_controller.sv
// Vending controller: coin accumulation, product selection with sold-out
// check, single-item dispense and greedy change payout over a ready/valid
// handshake.
// Optional feature macro: VEND_CARD_EN (card payment; when undefined the
// pay_card/card_balance inputs are ignored and debit_valid stays 0).
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   cost_flat           price table, product i at [i*PRICE_W +: PRICE_W]
//   inv_load            load stock table from inv_init_flat (IDLE only)
//   inv_init_flat       initial stock, product i at [i*INV_W +: INV_W]
//   sel_valid/sel_index selection strobe and product index
//   nickel..dollar      one-cycle coin pulses, summed when coincident
//   cancel              abort and refund full credit
//   pay_card            card payment request
//   card_balance        card funds available
//   change_ready        payout accepted
//   credit              current coin credit
//   coin_reject         pulse: coins of the previous cycle refused
//   sold_out            pulse: previous selection had zero stock
//   dispense/disp_index item released and which product
//   inv_flat            live stock table
//   change_valid        payout counts valid
//   quart/dim/nick      change coin counts
//   debit_valid         pulse with dispense when the card paid
module vending_controller
  import vend_pkg::*;
#(
  parameter  int N_PROD   = 8,
  parameter  int PRICE_W  = 8,
  parameter  int INV_W    = 3,
  parameter  int CREDIT_W = 9,
  localparam int IDX_W    = $clog2(N_PROD)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PROD*PRICE_W-1:0] cost_flat,
  input  logic                      inv_load,
  input  logic [N_PROD*INV_W-1:0]   inv_init_flat,
  input  logic                      sel_valid,
  input  logic [IDX_W-1:0]          sel_index,
  input  logic                      nickel,
  input  logic                      dime,
  input  logic                      quarter,
  input  logic                      dollar,
  input  logic                      cancel,
  input  logic                      pay_card,
  input  logic [CREDIT_W-1:0]       card_balance,
  input  logic                      change_ready,
  output logic [CREDIT_W-1:0]       credit,
  output logic                      coin_reject,
  output logic                      sold_out,
  output logic                      dispense,
  output logic [IDX_W-1:0]          disp_index,
  output logic [N_PROD*INV_W-1:0]   inv_flat,
  output logic                      change_valid,
  output logic [CREDIT_W-1:0]       quart,
  output logic [CREDIT_W-1:0]       dim,
  output logic [CREDIT_W-1:0]       nick,
  output logic                      debit_valid
);

  localparam int CW1 = CREDIT_W + 1;

  state_t              state;
  state_t              next_state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_next;
  logic [INV_W-1:0]    stock [N_PROD];
  logic                has_sel;
  logic [IDX_W-1:0]    sel_idx;
  logic                sold_out_q;
  logic                coin_reject_q;
  logic                card_vend;

  logic [CW1-1:0]      coin_add;
  logic [CW1-1:0]      credit_sum;
  logic                any_coin;
  logic                coin_accept;
  logic [PRICE_W-1:0]  sel_cost;
  logic [CREDIT_W-1:0] sel_cost_c;
  logic                sel_stock_nz;
  logic                pre_vend;
  logic                vend_ok;
  logic                card_ok;
  logic [CREDIT_W-1:0] calc_quart;
  logic [CREDIT_W-1:0] calc_dim;
  logic [CREDIT_W-1:0] calc_nick;

  // Sum of this cycle's coin pulses; coincident pulses all count.
  always_comb begin
    coin_add = '0;
    if (nickel)  coin_add = coin_add + CW1'(COIN_NICKEL);
    if (dime)    coin_add = coin_add + CW1'(COIN_DIME);
    if (quarter) coin_add = coin_add + CW1'(COIN_QUARTER);
    if (dollar)  coin_add = coin_add + CW1'(COIN_DOLLAR);
  end

  // The extra top bit of credit_sum flags an overflow: the whole cycle's
  // coins are then refused. Coins are never taken while change is pending.
  assign any_coin     = nickel | dime | quarter | dollar;
  assign credit_sum   = {1'b0, credit_q} + coin_add;
  assign coin_accept  = any_coin && (state != CHANGE) && !credit_sum[CREDIT_W];

  assign sel_cost     = cost_flat[int'(sel_idx)*PRICE_W +: PRICE_W];
  assign sel_cost_c   = CREDIT_W'(sel_cost);
  assign sel_stock_nz = (stock[sel_idx] != '0);
  assign pre_vend     = (state == IDLE) || (state == COLLECT);
  assign vend_ok      = has_sel && sel_stock_nz && (credit_q >= sel_cost_c);

`ifdef VEND_CARD_EN
  assign card_ok = pay_card && has_sel && sel_stock_nz && (card_balance >= sel_cost_c);
`else
  logic unused_card;
  assign card_ok     = 1'b0;
  assign unused_card = pay_card ^ (^card_balance);
`endif

  vend_change_calc #(
    .CREDIT_W (CREDIT_W)
  ) u_change_calc (
    .rem   (credit_q),
    .quart (calc_quart),
    .dim   (calc_dim),
    .nick  (calc_nick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: cancel beats a vend decision, which beats a new selection.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, COLLECT: begin
        if (cancel)                     next_state = CHANGE;
        else if (vend_ok || card_ok)    next_state = VEND;
        else if (sel_valid || any_coin) next_state = COLLECT;
      end
      VEND:   next_state = CHANGE;
      CHANGE: if (change_ready) next_state = IDLE;
    endcase
  end

  // FSM outputs. A cancel arriving during VEND suppresses the release.
  always_comb begin
    dispense     = 1'b0;
    disp_index   = '0;
    debit_valid  = 1'b0;
    change_valid = 1'b0;
    quart        = '0;
    dim          = '0;
    nick         = '0;
    unique case (state)
      VEND: begin
        if (!cancel) begin
          dispense   = 1'b1;
          disp_index = sel_idx;
`ifdef VEND_CARD_EN
          debit_valid = card_vend;
`endif
        end
      end
      CHANGE: begin
        change_valid = 1'b1;
        quart        = calc_quart;
        dim          = calc_dim;
        nick         = calc_nick;
      end
      default: ;
    endcase
  end

  // Credit update: coins first, then the price of a coin-paid item, and the
  // payout handshake empties the accumulator.
  always_comb begin
    credit_next = credit_q;
    if (coin_accept)                  credit_next = credit_sum[CREDIT_W-1:0];
    if (dispense && !card_vend)       credit_next = credit_next - sel_cost_c;
    if (change_valid && change_ready) credit_next = '0;
  end

  // Datapath registers: credit, selection, stock table and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q      <= '0;
      has_sel       <= 1'b0;
      sel_idx       <= '0;
      sold_out_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      card_vend     <= 1'b0;
      for (int i = 0; i < N_PROD; i++) stock[i] <= '0;
    end else begin
      credit_q      <= credit_next;
      coin_reject_q <= any_coin && !coin_accept;
      sold_out_q    <= 1'b0;
      card_vend     <= pre_vend && !cancel && !vend_ok && card_ok;

      if (state == VEND) begin
        has_sel <= 1'b0;
      end else if (pre_vend && cancel) begin
        has_sel <= 1'b0;
      end else if (pre_vend && !vend_ok && !card_ok && sel_valid) begin
        if (stock[sel_index] == '0) begin
          has_sel    <= 1'b0;
          sold_out_q <= 1'b1;
        end else begin
          has_sel <= 1'b1;
          sel_idx <= sel_index;
        end
      end

      if ((state == IDLE) && inv_load) begin
        for (int i = 0; i < N_PROD; i++) stock[i] <= inv_init_flat[i*INV_W +: INV_W];
      end else if (dispense && sel_stock_nz) begin
        stock[sel_idx] <= stock[sel_idx] - INV_W'(1);
      end
    end
  end

  assign credit      = credit_q;
  assign sold_out    = sold_out_q;
  assign coin_reject = coin_reject_q;

  for (genvar i = 0; i < N_PROD; i++) begin : g_inv
    assign inv_flat[i*INV_W +: INV_W] = stock[i];
  end

endmodule
